// File: rtl/uart_loader.sv
// UART serial boot loader: receives an A5/LEN/payload/XOR-checksum frame and writes words to instruction memory.
// Optional `UART_LOADER_AUTOBOOT_EN releases the core from reset immediately after rst_n.
module uart_loader #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        core_rst_n,
  output logic        busy,
  output logic        err,
  output logic        mem_w_en,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef UART_LOADER_AUTOBOOT_EN
  localparam logic CORE_RST_INIT = 1'b1;
`else
  localparam logic CORE_RST_INIT = 1'b0;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} ld_state_e;

  // ---------------- RX front end ----------------
  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_c;
  logic             frame_err_c;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // A start bit that is high again at mid-bit is treated as a glitch
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = CNT_W'(rx_cnt_q + 1'b1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = 3'(rx_bit_q + 1'b1);
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = CNT_W'(rx_cnt_q + 1'b1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d     = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_c = rx_s;
          frame_err_c  = !rx_s;
        end else begin
          rx_cnt_d = CNT_W'(rx_cnt_q + 1'b1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Frame FSM ----------------
  ld_state_e   state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] word_q, word_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [31:0] mem_w_addr_q, mem_w_addr_d;
  logic [31:0] mem_w_data_q, mem_w_data_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [15:0] len_full_c;
  logic [15:0] idx_inc_c;
  logic [31:0] word_nx_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      mem_w_en_q   <= 1'b0;
      mem_w_addr_q <= '0;
      mem_w_data_q <= '0;
      core_rst_n_q <= CORE_RST_INIT;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_w_data_q <= mem_w_data_d;
      core_rst_n_q <= core_rst_n_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    word_d       = word_q;
    mem_w_en_d   = 1'b0;
    mem_w_addr_d = mem_w_addr_q;
    mem_w_data_d = mem_w_data_q;
    core_rst_n_d = core_rst_n_q;
    err_d        = err_q;
    len_full_c   = {rx_shift_q, len_q[7:0]};
    idx_inc_c    = 16'(idx_q + 16'd1);
    word_nx_c    = word_q;
    word_nx_c[{byte_cnt_q, 3'b000} +: 8] = rx_shift_q;

    if (frame_err_c) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end else if (byte_valid_c) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (rx_shift_q == SYNC_BYTE) begin
            state_d      = ST_LEN0;
            err_d        = 1'b0;
            core_rst_n_d = 1'b0;
            idx_d        = '0;
            byte_cnt_d   = '0;
            csum_d       = '0;
          end
        end
        ST_LEN0: begin
          len_d   = {8'h00, rx_shift_q};
          state_d = ST_LEN1;
        end
        ST_LEN1: begin
          len_d = len_full_c;
          if (32'(len_full_c) > MAX_WORDS) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (len_full_c == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          word_d     = word_nx_c;
          csum_d     = csum_q ^ rx_shift_q;
          byte_cnt_d = 2'(byte_cnt_q + 1'b1);
          // Fourth lane completes the word: issue the write
          if (byte_cnt_q == 2'd3) begin
            mem_w_en_d   = 1'b1;
            mem_w_addr_d = {14'b0, idx_q, 2'b00};
            mem_w_data_d = word_nx_c;
            idx_d        = idx_inc_c;
            if (idx_inc_c == len_q) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_shift_q == csum_q) begin
            state_d      = ST_DONE;
            core_rst_n_d = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
  end

  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_w_data = mem_w_data_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed frames plus random frames against a frame-level model.
module tb_uart_loader;

  localparam int unsigned DIV       = 10;
  localparam int unsigned MAX_WORDS = 1024;

`ifdef UART_LOADER_AUTOBOOT_EN
  localparam logic RST_CORE = 1'b1;
`else
  localparam logic RST_CORE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        core_rst_n;
  logic        busy;
  logic        err;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [7:0]  tx_q[$];
  logic [31:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        exp_err;

  uart_loader #(
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .err       (err),
    .mem_w_en  (mem_w_en),
    .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every write strobe seen away from the active edge
  always @(negedge clk) begin
    if (mem_w_en) got_q.push_back({mem_w_addr, mem_w_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_bits(input int unsigned n);
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  // Frame-level reference: what a loader must write and report for the bytes in tx_q
  task automatic model_frame();
    int unsigned n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_q.delete();
    n  = {tx_q[2], tx_q[1]};
    cs = 8'h00;
    if (n > MAX_WORDS) begin
      exp_err = 1'b1;
    end else begin
      for (int unsigned i = 0; i < n; i++) begin
        w = 32'h0;
        for (int unsigned b = 0; b < 4; b++) begin
          w  = w | (32'(tx_q[3 + 4*i + b]) << (8*b));
          cs = cs ^ tx_q[3 + 4*i + b];
        end
        exp_q.push_back(w);
      end
      exp_err = (tx_q[3 + 4*n] != cs);
    end
  endtask

  task automatic send_frame();
    got_q.delete();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    wait_bits(2);
  endtask

  task automatic check_frame(input string tag);
    check({tag, ".nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("%s.addr%0d", tag, i), got_q[i][63:32], 32'(i * 4));
        check($sformatf("%s.data%0d", tag, i), got_q[i][31:0], exp_q[i]);
      end
    end
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    check({tag, ".core"}, 32'(core_rst_n), 32'(!exp_err));
    check({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".wen"}, 32'(mem_w_en), 32'h0);
    check({tag, ".addr"}, mem_w_addr, 32'h0);
    check({tag, ".data"}, mem_w_data, 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".err"}, 32'(err), 32'h0);
    check({tag, ".core"}, 32'(core_rst_n), 32'(RST_CORE));
  endtask

  initial begin
    int unsigned n;
    logic [7:0]  cs;
    logic [7:0]  b;
    n_checks = 0;
    n_errors = 0;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_bits(2);

    // Reference two-word frame; sync alone must grab the core and mark busy
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    model_frame();
    got_q.delete();
    send_byte(tx_q[0], 1'b1);
    check("sync.busy", 32'(busy), 32'h1);
    check("sync.core", 32'(core_rst_n), 32'h0);
    for (int i = 1; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
    wait_bits(2);
    check_frame("good2");

    // Same frame with a bad checksum, then recovery with a one-word frame
    tx_q[11] = 8'h01;
    model_frame();
    send_frame();
    check_frame("badcs");
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    model_frame();
    send_frame();
    check_frame("recover");

    // Empty image and oversized length
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_frame();
    send_frame();
    check_frame("empty");
    tx_q = '{8'hA5, 8'h01, 8'h04};
    model_frame();
    send_frame();
    check_frame("toolong");

    // Short low glitch between LEN0 and LEN1 must not produce a byte
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    model_frame();
    got_q.delete();
    send_byte(tx_q[0], 1'b1);
    send_byte(tx_q[1], 1'b1);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    wait_bits(2);
    for (int i = 2; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
    wait_bits(2);
    check_frame("glitch");

    // Framing error on the LEN0 byte
    got_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b0);
    wait_bits(3);
    check("ferr.err", 32'(err), 32'h1);
    check("ferr.busy", 32'(busy), 32'h0);
    check("ferr.core", 32'(core_rst_n), 32'h0);
    check("ferr.nwr", 32'(got_q.size()), 32'h0);

    // Reset mid-payload aborts without any write
    got_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_bits(2);
    check("abort.nwr", 32'(got_q.size()), 32'h0);
    check("abort.core2", 32'(core_rst_n), 32'(RST_CORE));

    // Random frames, roughly one in four with a corrupted checksum
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 4);
      tx_q = '{8'hA5, 8'(n), 8'h00};
      cs = 8'h00;
      for (int unsigned i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        tx_q.push_back(b);
        cs = cs ^ b;
      end
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      tx_q.push_back(cs);
      model_frame();
      send_frame();
      check_frame($sformatf("rnd%0d", f));
      wait_bits($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
